// File: rtl/z80_bus_arbiter_if.sv
// Signal bundle for the two requester handshakes (CPU, DMA) and the shared Z80 bus pins.
interface z80_bus_arbiter_if;
  logic        cpu_req;
  logic [1:0]  cpu_kind;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic        dma_req;
  logic [1:0]  dma_kind;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  rdata;
  logic        nWAIT;
  logic [7:0]  READ_D;
  logic [15:0] A;
  logic [7:0]  WRITE_D;
  logic        nMREQ;
  logic        nIORQ;
  logic        nRD;
  logic        nWR;
  logic        busy;

  modport slave (
    input  cpu_req, cpu_kind, cpu_addr, cpu_wdata,
    input  dma_req, dma_kind, dma_addr, dma_wdata,
    input  nWAIT, READ_D,
    output cpu_ack, dma_ack, rdata, A, WRITE_D,
    output nMREQ, nIORQ, nRD, nWR, busy
  );

  modport master (
    output cpu_req, cpu_kind, cpu_addr, cpu_wdata,
    output dma_req, dma_kind, dma_addr, dma_wdata,
    output nWAIT, READ_D,
    input  cpu_ack, dma_ack, rdata, A, WRITE_D,
    input  nMREQ, nIORQ, nRD, nWR, busy
  );
endinterface

// File: rtl/z80_bus_arbiter.sv
// Round-robin arbiter sharing one Z80 memory/IO bus between the CPU sequencer and a DMA engine.
// Each transaction runs IDLE -> SETUP -> ACCESS (wait states + nWAIT) -> DONE with registered strobes.
module z80_bus_arbiter #(
  parameter int MEM_WAIT = 0,
  parameter int IO_WAIT  = 1,
  parameter int WAIT_W   = 4
) (
  input logic              CLK,
  input logic              nRESET,
  z80_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [WAIT_W-1:0] MEM_CNT = WAIT_W'(MEM_WAIT);
  localparam logic [WAIT_W-1:0] IO_CNT  = WAIT_W'(IO_WAIT);

  state_t            state;
  logic              last_grant;   // 0 = CPU, 1 = DMA
  logic              grant_port;
  logic [1:0]        kind;         // kind[1]: IO, kind[0]: write
  logic [WAIT_W-1:0] cnt;

  logic              pick_dma;
  logic [1:0]        sel_kind;
  logic [15:0]       sel_addr;
  logic [7:0]        sel_wdata;

  // On a tie the port that was not served last wins.
  always_comb begin
    pick_dma  = bus.dma_req && (!bus.cpu_req || !last_grant);
    sel_kind  = pick_dma ? bus.dma_kind  : bus.cpu_kind;
    sel_addr  = pick_dma ? bus.dma_addr  : bus.cpu_addr;
    sel_wdata = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant_port  <= 1'b0;
      kind        <= 2'b00;
      cnt         <= '0;
      bus.nMREQ   <= 1'b1;
      bus.nIORQ   <= 1'b1;
      bus.nRD     <= 1'b1;
      bus.nWR     <= 1'b1;
      bus.A       <= 16'h0000;
      bus.WRITE_D <= 8'h00;
      bus.rdata   <= 8'h00;
      bus.cpu_ack <= 1'b0;
      bus.dma_ack <= 1'b0;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.dma_req) begin
            grant_port  <= pick_dma;
            last_grant  <= pick_dma;
            kind        <= sel_kind;
            bus.A       <= sel_addr;
            bus.WRITE_D <= sel_kind[0] ? sel_wdata : 8'h00;
            state       <= SETUP;
          end
        end
        SETUP: begin
          cnt       <= kind[1] ? IO_CNT : MEM_CNT;
          bus.nMREQ <= kind[1];
          bus.nIORQ <= !kind[1];
          bus.nRD   <= kind[0];
          bus.nWR   <= !kind[0];
          state     <= ACCESS;
        end
        ACCESS: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          // Leave only once the programmed wait states are spent and the bus is not stalling.
          if (cnt == '0 && bus.nWAIT) begin
            bus.nMREQ <= 1'b1;
            bus.nIORQ <= 1'b1;
            bus.nRD   <= 1'b1;
            bus.nWR   <= 1'b1;
            if (!kind[0]) bus.rdata <= bus.READ_D;
            if (grant_port) bus.dma_ack <= 1'b1;
            else            bus.cpu_ack <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed and randomized bench for z80_bus_arbiter against a transaction-level timing model.
module tb_z80_bus_arbiter;
  localparam int MEM_WAIT = 0;
  localparam int IO_WAIT  = 1;

  logic clk = 1'b0;
  logic nreset;

  z80_bus_arbiter_if bus ();

  z80_bus_arbiter #(.MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT), .WAIT_W(4)) dut (
    .CLK    (clk),
    .nRESET (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: one record for the transaction currently owning the bus, located in time by cycle numbers.
  bit          m_active, m_exited, m_port, m_last;
  int          m_setup, m_done;
  logic [1:0]  m_kind;
  logic [15:0] m_a;
  logic [7:0]  m_wd, m_rdata;

  // Inputs as seen by the upcoming clock edge.
  bit          c_creq, c_dreq, c_nwait;
  logic [1:0]  c_ck, c_dk;
  logic [15:0] c_ca, c_da;
  logic [7:0]  c_cw, c_dw, c_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_exited = 1'b0; m_port = 1'b0; m_last = 1'b1;
    m_setup = 0; m_done = 0; m_kind = 2'b00;
    m_a = 16'h0000; m_wd = 8'h00; m_rdata = 8'h00;
  endtask

  function automatic bit m_ack(input bit port);
    return m_active && m_exited && (cyc == m_done) && (m_port == port);
  endfunction

  task automatic model_edge();
    int waits;
    if (!m_active) begin
      if (c_creq || c_dreq) begin
        if (c_creq && c_dreq) m_port = !m_last;
        else                  m_port = c_dreq;
        m_last   = m_port;
        m_kind   = m_port ? c_dk : c_ck;
        m_a      = m_port ? c_da : c_ca;
        m_wd     = m_kind[0] ? (m_port ? c_dw : c_cw) : 8'h00;
        m_active = 1'b1;
        m_exited = 1'b0;
        m_setup  = cyc;
      end
    end else if (!m_exited) begin
      waits = m_kind[1] ? IO_WAIT : MEM_WAIT;
      // Cycle cyc-1 was access cycle number (cyc - m_setup - 2), counted from zero.
      if ((cyc - m_setup - 2) >= waits && c_nwait) begin
        m_exited = 1'b1;
        m_done   = cyc;
        if (!m_kind[0]) m_rdata = c_rd;
      end
    end else if (cyc == m_done + 1) begin
      m_active = 1'b0;
    end
  endtask

  task automatic check_outputs();
    bit acc;
    acc = m_active && !m_exited && (cyc > m_setup);
    chk("strobes", {bus.nMREQ, bus.nIORQ, bus.nRD, bus.nWR},
        {!(acc && !m_kind[1]), !(acc && m_kind[1]), !(acc && !m_kind[0]), !(acc && m_kind[0])});
    chk("cpu_ack", bus.cpu_ack, m_ack(1'b0));
    chk("dma_ack", bus.dma_ack, m_ack(1'b1));
    chk("busy", bus.busy, m_active);
    chk("A", bus.A, m_a);
    chk("WRITE_D", bus.WRITE_D, m_wd);
    chk("rdata", bus.rdata, m_rdata);
    chk("inv_mreq_iorq", bus.nMREQ | bus.nIORQ, 1'b1);
    chk("inv_rd_wr", bus.nRD | bus.nWR, 1'b1);
    chk("inv_acks", bus.cpu_ack & bus.dma_ack, 1'b0);
  endtask

  task automatic step();
    c_creq = bus.cpu_req; c_ck = bus.cpu_kind; c_ca = bus.cpu_addr; c_cw = bus.cpu_wdata;
    c_dreq = bus.dma_req; c_dk = bus.dma_kind; c_da = bus.dma_addr; c_dw = bus.dma_wdata;
    c_nwait = bus.nWAIT;  c_rd = bus.READ_D;
    @(posedge clk);
    #1;
    cyc++;
    if (!nreset) model_reset();
    else         model_edge();
    check_outputs();
  endtask

  task automatic set_cpu(input bit req, input logic [1:0] k, input logic [15:0] a, input logic [7:0] d);
    bus.cpu_req = req; bus.cpu_kind = k; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_dma(input bit req, input logic [1:0] k, input logic [15:0] a, input logic [7:0] d);
    bus.dma_req = req; bus.dma_kind = k; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  int ack_port[$];
  int ack_cyc[$];

  initial begin
    nreset = 1'b0;
    set_cpu(1'b0, 2'b00, 16'h0000, 8'h00);
    set_dma(1'b0, 2'b00, 16'h0000, 8'h00);
    bus.nWAIT  = 1'b1;
    bus.READ_D = 8'h00;
    model_reset();
    repeat (2) step();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_A", bus.A, 16'h0000);
    nreset = 1'b1;
    step();

    // Test 1: CPU memory read, no wait states.
    set_cpu(1'b1, 2'b00, 16'h1234, 8'h00);
    bus.READ_D = 8'hA5;
    step();
    chk("t1_A_c1", bus.A, 16'h1234);
    chk("t1_mreq_c1", bus.nMREQ, 1'b1);
    step();
    chk("t1_mreq_rd_c2", {bus.nMREQ, bus.nRD}, 2'b00);
    step();
    chk("t1_ack_c3", bus.cpu_ack, 1'b1);
    chk("t1_rdata_c3", bus.rdata, 8'hA5);
    chk("t1_A_c3", bus.A, 16'h1234);
    chk("t1_mreq_c3", bus.nMREQ, 1'b1);
    bus.cpu_req = 1'b0;
    step();

    // Test 2: DMA IO write with one IO wait state.
    set_dma(1'b1, 2'b11, 16'h00FE, 8'h3C);
    bus.READ_D = 8'h77;
    step();
    chk("t2_wdata_c1", bus.WRITE_D, 8'h3C);
    step();
    chk("t2_iorq_wr_c2", {bus.nIORQ, bus.nWR}, 2'b00);
    step();
    chk("t2_iorq_wr_c3", {bus.nIORQ, bus.nWR}, 2'b00);
    chk("t2_no_ack_c3", bus.dma_ack, 1'b0);
    step();
    chk("t2_ack_c4", bus.dma_ack, 1'b1);
    chk("t2_rdata_kept", bus.rdata, 8'hA5);
    bus.dma_req = 1'b0;
    step();

    // Test 3: both ports requesting continuously; grants must alternate.
    set_cpu(1'b1, 2'b00, 16'h1111, 8'h00);
    set_dma(1'b1, 2'b00, 16'h2222, 8'h00);
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.cpu_ack) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
      if (bus.dma_ack) begin ack_port.push_back(1); ack_cyc.push_back(cyc); end
    end
    chk("t3_ack_count_ge4", ack_port.size() >= 4, 1'b1);
    if (ack_port.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("t3_grant_order", ack_port[i], i % 2);
      for (int i = 1; i < 4; i++) chk("t3_ack_spacing", ack_cyc[i] - ack_cyc[i-1], 4);
    end
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    repeat (6) step();

    // Test 4: nWAIT stall of three cycles on a memory read.
    set_cpu(1'b1, 2'b00, 16'h4000, 8'h00);
    for (int k = 0; k < 7; k++) begin
      bus.nWAIT  = !(k >= 2 && k <= 4);
      bus.READ_D = 8'h10 + 8'(k);
      if (k == 6) bus.cpu_req = 1'b0;
      step();
      chk("t4_ack_timing", bus.cpu_ack, (k + 1) == 6);
      if (k + 1 == 6) chk("t4_rdata", bus.rdata, 8'h15);
    end
    bus.nWAIT = 1'b1;
    step();

    // Test 5: asynchronous reset in the middle of ACCESS, then a tie.
    set_cpu(1'b1, 2'b00, 16'h5555, 8'h00);
    step();
    step();
    chk("t5_in_access", bus.nMREQ, 1'b0);
    #3 nreset = 1'b0;
    #1;
    model_reset();
    chk("t5_async_strobes", {bus.nMREQ, bus.nIORQ, bus.nRD, bus.nWR}, 4'hF);
    chk("t5_async_busy", bus.busy, 1'b0);
    chk("t5_async_A", bus.A, 16'h0000);
    bus.cpu_req = 1'b0;
    step();
    nreset = 1'b1;
    step();
    set_cpu(1'b1, 2'b00, 16'h6000, 8'h00);
    set_dma(1'b1, 2'b00, 16'h7000, 8'h00);
    step();
    step();
    step();
    chk("t5_tie_cpu_ack", bus.cpu_ack, 1'b1);
    chk("t5_tie_dma_quiet", bus.dma_ack, 1'b0);
    bus.cpu_req = 1'b0;
    repeat (4) step();
    chk("t5_dma_ack", bus.dma_ack, 1'b1);
    bus.dma_req = 1'b0;
    step();

    // Test 6: CPU changes its address after being granted.
    set_cpu(1'b1, 2'b01, 16'h1234, 8'h5A);
    step();
    bus.cpu_addr  = 16'hBEEF;
    bus.cpu_wdata = 8'hFF;
    step();
    chk("t6_A_c2", bus.A, 16'h1234);
    chk("t6_wdata_c2", bus.WRITE_D, 8'h5A);
    step();
    chk("t6_A_c3", bus.A, 16'h1234);
    chk("t6_ack_c3", bus.cpu_ack, 1'b1);
    bus.cpu_req = 1'b0;
    step();

    // Random traffic from both requesters with random stalls and read data.
    for (int i = 0; i < 500; i++) begin
      if (m_ack(1'b0)) bus.cpu_req = 1'b0;
      else if (!bus.cpu_req && $urandom_range(0, 2) == 0)
        set_cpu(1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 8'($urandom));
      if (m_ack(1'b1)) bus.dma_req = 1'b0;
      else if (!bus.dma_req && $urandom_range(0, 2) == 0)
        set_dma(1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 8'($urandom));
      bus.nWAIT  = ($urandom_range(0, 3) != 0);
      bus.READ_D = 8'($urandom);
      step();
    end

    // Drain: no new requests, held ones finish.
    bus.nWAIT = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (m_ack(1'b0)) bus.cpu_req = 1'b0;
      if (m_ack(1'b1)) bus.dma_req = 1'b0;
      step();
    end
    chk("drain_idle", bus.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
